// File: rtl/wishbone_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_pkg
// Purpose  : Shared types, widths and helpers for the Wishbone subordinate
//            register bank.
// Contents : wb_sub_state_t  - responder FSM states
//            WB_DAT_W        - data bus width
//            WB_SEL_W        - byte-select width
//            byte_merge()    - per-lane merge of new data into an old word
// Revision : 1.0 - initial release
// ============================================================================
package wishbone_pkg;

    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } wb_sub_state_t;

    // Lane n takes new_w when sel[n] is set, otherwise keeps old_w.
    function automatic logic [WB_DAT_W-1:0] byte_merge(
        input logic [WB_DAT_W-1:0] old_w,
        input logic [WB_DAT_W-1:0] new_w,
        input logic [WB_SEL_W-1:0] sel
    );
        logic [WB_DAT_W-1:0] result;
        result = old_w;
        for (int n = 0; n < WB_SEL_W; n++) begin
            if (sel[n]) begin
                result[8*n +: 8] = new_w[8*n +: 8];
            end
        end
        return result;
    endfunction

endpackage : wishbone_pkg
`default_nettype wire

// File: rtl/wishbone_regbank_store.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_regbank_store
// Purpose  : Read/write control register storage with byte-lane merge and a
//            one-cycle per-register write pulse.
// Ports    : CLK        - system clock
//            nRST       - synchronous active-low reset
//            wr_en_i    - commit strobe for a write (any index)
//            wr_idx_i   - register index; indices >= NUM_RW never match
//            wr_dat_i   - write data
//            wr_sel_i   - byte lane enables
//            reg_o      - flattened register contents, reg i at [32i+31:32i]
//            wr_pulse_o - per-register pulse, high the cycle after commit
// Revision : 1.0 - initial release
// ============================================================================
module wishbone_regbank_store
    import wishbone_pkg::*;
#(
    parameter int NUM_RW = 8,
    parameter int IDX_W  = 4
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       wr_en_i,
    input  logic [IDX_W-1:0]           wr_idx_i,
    input  logic [WB_DAT_W-1:0]        wr_dat_i,
    input  logic [WB_SEL_W-1:0]        wr_sel_i,
    output logic [WB_DAT_W*NUM_RW-1:0] reg_o,
    output logic [NUM_RW-1:0]          wr_pulse_o
);

    for (genvar i = 0; i < NUM_RW; i++) begin : g_reg
        logic [WB_DAT_W-1:0] reg_q;
        logic [WB_DAT_W-1:0] reg_d;
        logic                pulse_q;
        logic                sel_w;

        assign sel_w = wr_en_i && (wr_idx_i == IDX_W'(i));

        always_comb begin
            reg_d = reg_q;
            if (sel_w) begin
                reg_d = byte_merge(reg_q, wr_dat_i, wr_sel_i);
            end
        end

        always_ff @(posedge CLK) begin
            if (!nRST) begin
                reg_q   <= '0;
                pulse_q <= 1'b0;
            end else begin
                reg_q   <= reg_d;
                // A write with no lanes enabled is acknowledged silently.
                pulse_q <= sel_w && (|wr_sel_i);
            end
        end

        assign reg_o[WB_DAT_W*i +: WB_DAT_W] = reg_q;
        assign wr_pulse_o[i]                 = pulse_q;
    end

endmodule : wishbone_regbank_store
`default_nettype wire

// File: rtl/wishbone_subordinate_regbank.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_subordinate_regbank
// Purpose  : Wishbone classic subordinate exposing NUM_RW read/write control
//            registers followed by NUM_RO read-only status registers, with a
//            fixed number of wait states before the single-cycle ACK.
// Ports    : CLK, nRST   - clock, synchronous active-low reset
//            wbs_cyc_i   - bus cycle valid
//            wbs_stb_i   - transfer request
//            wbs_we_i    - 1 = write, 0 = read
//            wbs_adr_i   - byte address
//            wbs_dat_i   - write data
//            wbs_sel_i   - byte lane enables (writes only)
//            wbs_ack_o   - one-cycle acknowledge per accepted transfer
//            wbs_dat_o   - read data, zero outside the ACK cycle
//            reg_o       - flattened R/W register contents
//            ro_i        - flattened status inputs
//            wr_pulse_o  - per-register write pulse, coincident with ACK
// Revision : 1.0 - initial release
// ============================================================================
module wishbone_subordinate_regbank
    import wishbone_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          NUM_RW      = 8,
    parameter int          NUM_RO      = 4,
    parameter int          WAIT_STATES = 1
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       wbs_cyc_i,
    input  logic                       wbs_stb_i,
    input  logic                       wbs_we_i,
    input  logic [31:0]                wbs_adr_i,
    input  logic [WB_DAT_W-1:0]        wbs_dat_i,
    input  logic [WB_SEL_W-1:0]        wbs_sel_i,
    output logic                       wbs_ack_o,
    output logic [WB_DAT_W-1:0]        wbs_dat_o,
    output logic [WB_DAT_W*NUM_RW-1:0] reg_o,
    input  logic [WB_DAT_W*NUM_RO-1:0] ro_i,
    output logic [NUM_RW-1:0]          wr_pulse_o
);

    localparam int c_NUM_REGS = NUM_RW + NUM_RO;
    localparam int c_IDX_W    = (c_NUM_REGS > 1) ? $clog2(c_NUM_REGS) : 1;
    localparam int c_CNT_W    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [32:0]        c_WIN_BYTES = 33'(4 * c_NUM_REGS);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD  =
        (WAIT_STATES > 0) ? c_CNT_W'(WAIT_STATES - 1) : '0;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]        w_off;
    logic               w_cycstb;
    logic               w_hit;
    logic [c_IDX_W-1:0] w_idx;

    assign w_off    = wbs_adr_i - BASE_ADDR;
    assign w_cycstb = wbs_cyc_i && wbs_stb_i;
    // The lower-bound test keeps addresses below BASE_ADDR from wrapping
    // into the window through the subtraction.
    assign w_hit    = w_cycstb && (wbs_adr_i >= BASE_ADDR) &&
                      ({1'b0, w_off} < c_WIN_BYTES);
    assign w_idx    = w_off[c_IDX_W+1:2];

    // ------------------------------------------------------------------
    // FSM state and latched request
    // ------------------------------------------------------------------
    wb_sub_state_t       state_q;
    logic [c_CNT_W-1:0]  cnt_q;
    logic [c_IDX_W-1:0]  idx_q;
    logic                we_q;
    logic [WB_DAT_W-1:0] dat_q;
    logic [WB_SEL_W-1:0] sel_q;
    logic                ack_q;
    logic [WB_DAT_W-1:0] rdat_q;

    // ------------------------------------------------------------------
    // Commit: asserted on the edge that enters ACK. With zero wait states
    // that edge is also the accept edge, so the bus inputs are used
    // directly instead of the (not yet loaded) latched copy.
    // ------------------------------------------------------------------
    logic                w_commit;
    logic [c_IDX_W-1:0]  w_cidx;
    logic                w_cwe;
    logic [WB_DAT_W-1:0] w_cdat;
    logic [WB_SEL_W-1:0] w_csel;
    logic [WB_DAT_W-1:0] w_rd;

    always_comb begin
        w_commit = 1'b0;
        w_cidx   = idx_q;
        w_cwe    = we_q;
        w_cdat   = dat_q;
        w_csel   = sel_q;
        case (state_q)
            IDLE: begin
                if ((WAIT_STATES == 0) && w_hit) begin
                    w_commit = 1'b1;
                    w_cidx   = w_idx;
                    w_cwe    = wbs_we_i;
                    w_cdat   = wbs_dat_i;
                    w_csel   = wbs_sel_i;
                end
            end
            WAIT: begin
                if (w_cycstb && (cnt_q == '0)) begin
                    w_commit = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Read mux: R/W registers first, then status inputs.
    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (w_cidx == c_IDX_W'(i)) begin
                w_rd = reg_o[WB_DAT_W*i +: WB_DAT_W];
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (w_cidx == c_IDX_W'(NUM_RW + j)) begin
                w_rd = ro_i[WB_DAT_W*j +: WB_DAT_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            dat_q   <= '0;
            sel_q   <= '0;
            ack_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            ack_q  <= w_commit;
            rdat_q <= (w_commit && !w_cwe) ? w_rd : '0;
            case (state_q)
                IDLE: begin
                    if (w_hit) begin
                        idx_q <= w_idx;
                        we_q  <= wbs_we_i;
                        dat_q <= wbs_dat_i;
                        sel_q <= wbs_sel_i;
                        if (WAIT_STATES == 0) begin
                            state_q <= ACK;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= c_CNT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!w_cycstb) begin
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - c_CNT_W'(1);
                    end
                end
                ACK: begin
                    // Never accepts here, so a held STB waits one idle cycle.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;

    // ------------------------------------------------------------------
    // R/W storage
    // ------------------------------------------------------------------
    wishbone_regbank_store #(
        .NUM_RW (NUM_RW),
        .IDX_W  (c_IDX_W)
    ) u_store (
        .CLK        (CLK),
        .nRST       (nRST),
        .wr_en_i    (w_commit && w_cwe),
        .wr_idx_i   (w_cidx),
        .wr_dat_i   (w_cdat),
        .wr_sel_i   (w_csel),
        .reg_o      (reg_o),
        .wr_pulse_o (wr_pulse_o)
    );

endmodule : wishbone_subordinate_regbank
`default_nettype wire

// File: tb/tb_wishbone_subordinate_regbank.sv
`default_nettype none
// ============================================================================
// Module   : tb_wishbone_subordinate_regbank
// Purpose  : Self-checking bench for wishbone_subordinate_regbank. The
//            driver pushes the expected response of every accepted transfer
//            into a queue; a monitor pops and compares on each ACK.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wishbone_subordinate_regbank;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam int          NRW  = 8;
    localparam int          NRO  = 4;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         cyc, stb, we;
    logic [31:0]  adr, dati;
    logic [3:0]   sel;
    logic         ack;
    logic [31:0]  dato;
    logic [255:0] reg_flat;
    logic [127:0] ro_flat;
    logic [7:0]   pulse;

    logic [31:0]  ro_m  [NRO];
    logic [31:0]  m_reg [NRW];

    always #5 CLK = ~CLK;

    assign ro_flat = {ro_m[3], ro_m[2], ro_m[1], ro_m[0]};

    wishbone_subordinate_regbank #(
        .BASE_ADDR   (BASE),
        .NUM_RW      (NRW),
        .NUM_RO      (NRO),
        .WAIT_STATES (1)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (dati),
        .wbs_sel_i  (sel),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (dato),
        .reg_o      (reg_flat),
        .ro_i       (ro_flat),
        .wr_pulse_o (pulse)
    );

    typedef struct {
        bit          rd;
        logic [31:0] data;
        logic [7:0]  pulse;
    } exp_t;

    exp_t q[$];
    int   n_vec  = 0;
    int   n_err  = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < NRW; i++) f[32*i +: 32] = m_reg[i];
        return f;
    endfunction

    // Monitor: every ACK consumes one expected response.
    always @(negedge CLK) begin : mon
        exp_t e;
        if (mon_en) begin
            if (ack === 1'b1) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ack: ack=1 with no pending transfer at %0t", $time);
                end else begin
                    e = q.pop_front();
                    if (e.rd) chk("rd_data", dato, e.data);
                    chk("wr_pulse", pulse, e.pulse);
                end
            end else begin
                chk("idle_dat_o", dato, 0);
                chk("idle_pulse", pulse, 0);
            end
        end
    end

    // One transfer. exp_lat counts rising edges from the first one at which
    // the request is presented up to the one after which ACK is visible.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input int exp_lat, input bit hold);
        bit   hit;
        int   idx;
        int   n;
        exp_t e;
        hit = (a >= BASE) && (a < BASE + 32'(4 * (NRW + NRO)));
        idx = int'((a - BASE) >> 2);
        if (hit) begin
            e.rd = !w; e.data = '0; e.pulse = '0;
            if (!w) begin
                e.data = (idx < NRW) ? m_reg[idx] : ro_m[idx - NRW];
            end else if (idx < NRW) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
                if (s != 4'h0) e.pulse = 8'(1 << idx);
            end
            q.push_back(e);
        end
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dati = d; sel = s;
        n = 0;
        if (hit) begin
            do begin
                @(posedge CLK); #1; n++;
            end while (ack !== 1'b1 && n < 20);
            chk("ack_latency", n, exp_lat);
        end else begin
            repeat (10) @(posedge CLK);
            #1;
        end
        if (!hold) begin
            cyc = 1'b0; stb = 1'b0;
            @(posedge CLK); #1;
        end
        chk("reg_o", reg_flat, model_flat());
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] a;
        int          k;
        nRST = 1'b0; cyc = 0; stb = 0; we = 0; adr = 0; dati = 0; sel = 0;
        for (int i = 0; i < NRO; i++) ro_m[i] = '0;
        for (int i = 0; i < NRW; i++) m_reg[i] = '0;

        // Reset
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_dat_o", dato, 0);
        chk("rst_reg_o", reg_flat, 0);
        chk("rst_pulse", pulse, 0);
        nRST = 1'b1;
        mon_en = 1'b1;
        @(posedge CLK); #1;

        // Full-word write, then a single-lane write and read-back
        xfer(BASE + 32'h4, 1'b1, 32'hDEAD_BEEF, 4'hF, 2, 1'b0);
        chk("reg1_full", reg_flat[63:32], 32'hDEAD_BEEF);
        xfer(BASE + 32'h4, 1'b1, 32'h0000_AB00, 4'b0010, 2, 1'b0);
        chk("reg1_merge", reg_flat[63:32], 32'hDEAD_ABEF);
        xfer(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 2, 1'b0);

        // Status register read, write to RO is acked with no effect
        ro_m[0] = 32'h1234_5678;
        xfer(BASE + 32'h20, 1'b0, 32'h0, 4'hF, 2, 1'b0);
        xfer(BASE + 32'h20, 1'b1, 32'hFFFF_FFFF, 4'hF, 2, 1'b0);

        // Outside the window (above, first address past end, below)
        xfer(32'h3100_0000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
        xfer(BASE + 32'h30, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 1'b0);
        xfer(BASE - 32'h4, 1'b0, 32'h0, 4'hF, 0, 1'b0);

        // Abort in WAIT: strobe dropped before ACK
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h8; dati = 32'h5555_5555; sel = 4'hF;
        @(posedge CLK); #1;
        cyc = 0; stb = 0;
        repeat (4) @(posedge CLK);
        #1;
        chk("abort_reg_o", reg_flat, model_flat());

        // Reset while in WAIT
        xfer(BASE + 32'h0, 1'b1, 32'hA5A5_A5A5, 4'hF, 2, 1'b0);
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'hC; dati = 32'h7777_7777; sel = 4'hF;
        @(posedge CLK); #1;
        nRST = 1'b0; cyc = 0; stb = 0;
        @(posedge CLK); #1;
        chk("rst_wait_ack", ack, 0);
        chk("rst_wait_reg_o", reg_flat, 0);
        nRST = 1'b1;
        for (int i = 0; i < NRW; i++) m_reg[i] = '0;
        @(posedge CLK); #1;

        // Back-to-back reads with STB held across ACK
        xfer(BASE + 32'h8, 1'b1, 32'h0BAD_F00D, 4'hF, 2, 1'b0);
        xfer(BASE + 32'hC, 1'b1, 32'hC0FF_EE00, 4'hF, 2, 1'b0);
        ro_m[1] = 32'h9999_0001;
        xfer(BASE + 32'h8, 1'b0, 32'h0, 4'h0, 2, 1'b1);
        xfer(BASE + 32'hC, 1'b0, 32'h0, 4'h0, 3, 1'b1);
        xfer(BASE + 32'h24, 1'b0, 32'h0, 4'h0, 3, 1'b0);

        // Status input changes during WAIT: value at ACK entry is returned
        ro_m[2] = 32'h1111_1111;
        q.push_back('{rd: 1'b1, data: 32'h2222_2222, pulse: 8'h0});
        cyc = 1; stb = 1; we = 0; adr = BASE + 32'h28; sel = 4'h0;
        @(posedge CLK); #1;
        ro_m[2] = 32'h2222_2222;
        @(posedge CLK); #1;
        chk("ro_change_ack", ack, 1);
        cyc = 0; stb = 0;
        @(posedge CLK); #1;

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            for (int j = 0; j < NRO; j++) ro_m[j] = $urandom;
            k = int'($urandom_range(0, 13));
            if (k < 12)       a = BASE + 32'(4 * k) + 32'($urandom_range(0, 3));
            else if (k == 12) a = BASE + 32'h30 + 32'($urandom_range(0, 255));
            else              a = BASE - 32'($urandom_range(1, 64));
            xfer(a, 1'($urandom), $urandom, 4'($urandom), 2, 1'b0);
        end

        repeat (5) @(posedge CLK);
        #1;
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_wishbone_subordinate_regbank
`default_nettype wire
